// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the iterative core and its key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam logic [79:0] RCON_TAB = 80'h01020408102040801b36;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  // Out-of-range indices yield zero so a corrupted counter cannot read past the table.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    if (idx < 4'd10) return RCON_TAB[79 - 8*int'(idx) -: 8];
    else             return 8'h00;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational one-round key expansion step for 128- or 256-bit keys.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [127:0] k_prev_i,
  input  logic [127:0] k_cur_i,
  input  logic [3:0]   round_i,
  output logic [127:0] rkey_o,
  output logic [127:0] k_prev_o,
  output logic [127:0] k_cur_o
);

  logic [127:0] base_s;
  logic [127:0] gen_s;
  logic [31:0]  t_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [3:0]   rc_idx_s;
  logic         use_rot_s;

  // 128-bit keys rotate every round; 256-bit keys alternate, and round 1 reuses the key's low half.
  always_comb begin
    base_s    = (KEY_BITS == 128) ? k_cur_i : k_prev_i;
    use_rot_s = (KEY_BITS == 128) ? 1'b1 : ~round_i[0];
    rc_idx_s  = (KEY_BITS == 128) ? (round_i - 4'd1) : ({1'b0, round_i[3:1]} - 4'd1);
    if (use_rot_s) begin
      t_s = sub_word({k_cur_i[23:0], k_cur_i[31:24]}) ^ {rcon(rc_idx_s), 24'h000000};
    end else begin
      t_s = sub_word(k_cur_i[31:0]);
    end
    w0_s  = base_s[127:96] ^ t_s;
    w1_s  = base_s[95:64]  ^ w0_s;
    w2_s  = base_s[63:32]  ^ w1_s;
    w3_s  = base_s[31:0]   ^ w2_s;
    gen_s = {w0_s, w1_s, w2_s, w3_s};
    if ((KEY_BITS == 256) && (round_i == 4'd1)) begin
      rkey_o   = k_cur_i;
      k_prev_o = k_prev_i;
      k_cur_o  = k_cur_i;
    end else begin
      rkey_o   = gen_s;
      k_prev_o = k_cur_i;
      k_cur_o  = gen_s;
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one round per clock, on-the-fly key expansion,
// valid/ready on both sides with a single block in flight.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_state,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int         NR    = nr_of(KEY_BITS);
  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] FIN_L = 4'(NR + 1);

  if ((KEY_BITS != 128) && (KEY_BITS != 256)) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  aes_state_e   state_q;
  logic [127:0] blk_q, k_prev_q, k_cur_q, out_data_q;
  logic [3:0]   round_q;
  logic         out_valid_q, busy_q;
  logic [127:0] blk_d, k_prev_d, k_cur_d, rkey_s, sr_s, mc_s;
  logic         accept_s;

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .k_prev_i (k_prev_q),
    .k_cur_i  (k_cur_q),
    .round_i  (round_q),
    .rkey_o   (rkey_s),
    .k_prev_o (k_prev_d),
    .k_cur_o  (k_cur_d)
  );

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // One AES round: SubBytes+ShiftRows per byte, MixColumns skipped on the final round.
  always_comb begin
    sr_s = '0;
    mc_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127-8*(4*c+r) -: 8] = sbox(blk_q[127-8*(4*((c+r)%4)+r) -: 8]);
      end
      mc_s[127-32*c -: 32] = mix_col(sr_s[127-32*c -: 32]);
    end
    blk_d = ((round_q == NR_L) ? sr_s : mc_s) ^ rkey_s;
  end

  // Control FSM and datapath registers; the extra cycle at FIN_L moves the result to the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      k_prev_q    <= '0;
      k_cur_q     <= '0;
      round_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else if (accept_s) begin
      state_q     <= RUN;
      blk_q       <= in_state ^ in_key[KEY_BITS-1 -: 128];
      k_prev_q    <= in_key[KEY_BITS-1 -: 128];
      k_cur_q     <= in_key[127:0];
      round_q     <= 4'd1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        RUN: begin
          if (round_q == FIN_L) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= blk_q;
            busy_q      <= 1'b0;
          end else begin
            blk_q    <= blk_d;
            k_prev_q <= k_prev_d;
            k_cur_q  <= k_cur_d;
            round_q  <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 vector bench for aes_iter_core with 128- and 256-bit key instances.
module tb_aes_iter_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_state_a, in_key_a, out_data_a;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_state_b, out_data_b;
  logic [255:0] in_key_b;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_state(in_state_a), .in_key(in_key_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a)
  );

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_state(in_state_b), .in_key(in_key_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
  );

  task automatic wait_out_a(output int n);
    n = 0;
    while (out_valid_a !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_out_b(output int n);
    n = 0;
    while (out_valid_b !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_a = 1'b0; in_state_a = '0; in_key_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_state_b = '0; in_key_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({out_valid_a, busy_a, in_ready_a, out_data_a} !== {3'b001, 128'h0}) begin
      miscompares++;
      $display("FAIL reset128 got v=%b b=%b r=%b d=%h exp v=0 b=0 r=1 d=0", out_valid_a, busy_a, in_ready_a, out_data_a);
    end
    vectors++;
    if ({out_valid_b, busy_b, in_ready_b, out_data_b} !== {3'b001, 128'h0}) begin
      miscompares++;
      $display("FAIL reset256 got v=%b b=%b r=%b d=%h exp v=0 b=0 r=1 d=0", out_valid_b, busy_b, in_ready_b, out_data_b);
    end
  endtask

  task automatic test_fips128();
    int n;
    in_key_a = K1; in_state_a = P1; in_valid_a = 1'b1; out_ready_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_key_a = '1; in_state_a = '1;
    vectors++;
    if ({busy_a, in_ready_a} !== 2'b10) begin
      miscompares++;
      $display("FAIL fips128_run got busy=%b rdy=%b exp busy=1 rdy=0", busy_a, in_ready_a);
    end
    wait_out_a(n);
    vectors++;
    if (n !== 11) begin
      miscompares++;
      $display("FAIL fips128_latency got %0d exp 11", n);
    end
    vectors++;
    if (out_data_a !== C1) begin
      miscompares++;
      $display("FAIL fips128_data got %h exp %h", out_data_a, C1);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid_a, busy_a, in_ready_a} !== 3'b001) begin
      miscompares++;
      $display("FAIL fips128_drain got v=%b b=%b r=%b exp v=0 b=0 r=1", out_valid_a, busy_a, in_ready_a);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    in_key_a = K2; in_state_a = P2; in_valid_a = 1'b1; out_ready_a = 1'b1;
    @(posedge clk); #1;
    in_key_a = '0; in_state_a = '0;
    wait_out_a(n);
    vectors++;
    if (n !== 11 || out_data_a !== C2 || in_ready_a !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got n=%0d d=%h rdy=%b exp n=11 d=%h rdy=1", n, out_data_a, in_ready_a, C2);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    vectors++;
    if ({out_valid_a, busy_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_handover got v=%b busy=%b exp v=0 busy=1", out_valid_a, busy_a);
    end
    wait_out_a(n);
    vectors++;
    if (n !== 11 || out_data_a !== C0) begin
      miscompares++;
      $display("FAIL b2b_second got n=%0d d=%h exp n=11 d=%h", n, out_data_a, C0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aes256();
    int n;
    in_key_b = K3; in_state_b = P2; in_valid_b = 1'b1; out_ready_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0; in_key_b = '0; in_state_b = '0;
    wait_out_b(n);
    vectors++;
    if (n !== 15) begin
      miscompares++;
      $display("FAIL aes256_latency got %0d exp 15", n);
    end
    vectors++;
    if (out_data_b !== C3) begin
      miscompares++;
      $display("FAIL aes256_data got %h exp %h", out_data_b, C3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    in_key_a = K1; in_state_a = P1; in_valid_a = 1'b1; out_ready_a = 1'b0;
    @(posedge clk); #1;
    in_key_a = K2; in_state_a = P2;
    wait_out_a(n);
    vectors++;
    if (out_data_a !== C1) begin
      miscompares++;
      $display("FAIL bp_data got %h exp %h", out_data_a, C1);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid_a, in_ready_a, out_data_a} !== {2'b10, C1}) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b d=%h exp v=1 r=0 d=%h", i, out_valid_a, in_ready_a, out_data_a, C1);
      end
    end
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    #1;
    vectors++;
    if (in_ready_a !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_comb got %b exp 1", in_ready_a);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid_a, busy_a, in_ready_a} !== 3'b001) begin
      miscompares++;
      $display("FAIL bp_release got v=%b b=%b r=%b exp v=0 b=0 r=1", out_valid_a, busy_a, in_ready_a);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_single_transfer got v=%b exp 0", out_valid_a);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    in_key_a = '0; in_state_a = '0; in_valid_a = 1'b1; out_ready_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({out_valid_a, busy_a, in_ready_a, out_data_a} !== {3'b001, 128'h0}) begin
      miscompares++;
      $display("FAIL midrun_reset got v=%b b=%b r=%b d=%h exp v=0 b=0 r=1 d=0", out_valid_a, busy_a, in_ready_a, out_data_a);
    end
    in_key_a = K2; in_state_a = P2; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    wait_out_a(n);
    vectors++;
    if (n !== 11 || out_data_a !== C2) begin
      miscompares++;
      $display("FAIL midrun_fresh got n=%0d d=%h exp n=11 d=%h", n, out_data_a, C2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fips128();
    test_back_to_back();
    test_aes256();
    test_backpressure();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
